// File: rtl/bitsim_pkg.sv
// Shared defaults and FSM state type for the select generator.
// Optional feature macro: BIT_SEL_GEN_PERF_EN (perf_beats counter).
package bitsim_pkg;

    localparam int LANES_DEF     = 16;
    localparam int SEL_WIDTH_DEF = 5;
    localparam int SEL_ZERO      = LANES_DEF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/lsb_first_enc.sv
// Lowest-set-bit encoder: index of the lowest set lane, whether it is
// the only set lane, and whether any lane is set.
module lsb_first_enc
    import bitsim_pkg::*;
#(
    parameter int LANES     = LANES_DEF,
    parameter int SEL_WIDTH = SEL_WIDTH_DEF
) (
    input  logic [LANES-1:0]     i_pending,
    output logic [SEL_WIDTH-1:0] o_index,
    output logic                 o_one_hot_last,
    output logic                 o_any
);

    logic [LANES-1:0] w_rest;

    assign w_rest         = i_pending & (i_pending - LANES'(1));
    assign o_any          = |i_pending;
    assign o_one_hot_last = o_any && (w_rest == '0);

    // Scan high to low so the lowest set lane wins.
    always_comb begin
        o_index = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (i_pending[i]) begin
                o_index = SEL_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/bit_sel_gen.sv
// Converts a nonzero-lane mask into a stream of mux selects, lowest lane
// first. BIT_SEL_GEN_PERF_EN adds a 32-bit output-beat counter.
module bit_sel_gen
    import bitsim_pkg::*;
#(
    parameter int LANES     = LANES_DEF,
    parameter int SEL_WIDTH = SEL_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [LANES-1:0]     in_mask,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SEL_WIDTH-1:0] out_sel,
    output logic                 out_last
`ifdef BIT_SEL_GEN_PERF_EN
    ,
    output logic [31:0]          perf_beats
`endif
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LANES-1:0]       r_pending;
    logic [LANES-1:0]       w_pending_nxt;
    logic [LANES-1:0]       w_pending_clr;
    logic [SEL_WIDTH-1:0]   w_idx;
    logic                   w_one;
    logic                   w_any;
    logic                   w_in_fire;
    logic                   w_out_fire;

    lsb_first_enc #(
        .LANES     (LANES),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_enc (
        .i_pending      (r_pending),
        .o_index        (w_idx),
        .o_one_hot_last (w_one),
        .o_any          (w_any)
    );

    assign w_pending_clr = r_pending & (r_pending - LANES'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        out_valid     = 1'b0;
        out_sel       = '0;
        out_last      = 1'b0;
        in_ready      = 1'b0;
        w_in_fire     = 1'b0;
        w_out_fire    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                // An empty mask yields one bypass beat.
                out_sel   = w_any ? w_idx : SEL_WIDTH'(LANES);
                out_last  = w_one || !w_any;
                in_ready  = out_ready && out_last;
            end
            default: ;
        endcase
        w_in_fire  = in_valid && in_ready;
        w_out_fire = out_valid && out_ready;
        if (w_in_fire) begin
            w_pending_nxt = in_mask;
            w_state_nxt   = ST_EMIT;
        end else if (w_out_fire) begin
            if (out_last) begin
                w_pending_nxt = '0;
                w_state_nxt   = ST_IDLE;
            end else begin
                w_pending_nxt = w_pending_clr;
            end
        end
    end

`ifdef BIT_SEL_GEN_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf <= '0;
        end else if (w_out_fire) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_beats = r_perf;
`endif

endmodule

// File: tb/tb_bit_sel_gen.sv
// Scoreboard bench for bit_sel_gen: directed masks, stalls, reset abort.
module tb_bit_sel_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_mask;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_sel;
    logic        out_last;
`ifdef BIT_SEL_GEN_PERF_EN
    logic [31:0] perf_beats;
`endif

    int checks = 0;
    int errors = 0;
    int beats  = 0;
    logic [5:0] sb[$];

    always #5 clk = ~clk;

    bit_sel_gen dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_mask   (in_mask),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .out_last  (out_last)
`ifdef BIT_SEL_GEN_PERF_EN
        ,
        .perf_beats(perf_beats)
`endif
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_mask(input logic [15:0] m);
        logic [15:0] hi;
        if (m == 16'h0000) begin
            sb.push_back({1'b1, 5'd16});
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (m[i]) begin
                    hi = m >> (i + 1);
                    sb.push_back({(hi == 16'h0000), 5'(i)});
                end
            end
        end
    endtask

    task automatic send(input logic [15:0] m);
        int n = 0;
        in_valid = 1'b1;
        in_mask  = m;
        #1;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_wait", (n < 100), 1);
        push_mask(m);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mask  = 16'hDEAD;
        check("valid_after_accept", out_valid, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_sb_empty", sb.size(), 0);
        check("drain_valid_low", out_valid, 0);
    endtask

    // Monitor: a beat is taken at the edge following this sample.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got sel=%0d last=%0d expected none",
                         out_sel, out_last);
            end else begin
                check("beat", {26'd0, out_last, out_sel}, {26'd0, sb.pop_front()});
            end
            beats++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mask   = 16'h0000;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sel", out_sel, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        send(16'h0000);
        check("zero_in_ready_same", in_ready, 1);
        @(posedge clk);
        #1;
        check("zero_valid_done", out_valid, 0);
        check("zero_in_ready_next", in_ready, 1);
        drain();

        base = beats;
        send(16'h8421);
        repeat (4) @(posedge clk);
        #1;
        check("m8421_beats", beats - base, 4);
        check("m8421_done", out_valid, 0);
        drain();

        base = beats;
        send(16'h0006);
        send(16'h0001);
        check("b2b_beats_mid", beats - base, 2);
        @(posedge clk);
        #1;
        check("b2b_beats_end", beats - base, 3);
        check("b2b_done", out_valid, 0);
        drain();

        out_ready = 1'b0;
        send(16'h0030);
        repeat (3) begin
            check("stall_valid", out_valid, 1);
            check("stall_sel", out_sel, 4);
            check("stall_last", out_last, 0);
            @(posedge clk);
            #1;
        end
        base = beats;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("stall_beats", beats - base, 2);
        drain();

        base = beats;
        send(16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check("abort_beats_before", beats - base, 3);
        reset = 1'b1;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_sel", out_sel, 0);
        check("abort_last", out_last, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_quiet_valid", out_valid, 0);
        check("abort_quiet_beats", beats - base, 3);
        check("abort_in_ready", in_ready, 1);

        send(16'h0003);
        send(16'h0000);
        drain();
`ifdef BIT_SEL_GEN_PERF_EN
        check("perf_beats", perf_beats, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
